// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter onto a single memory port: round-robin on ties,
// grant held until all read beats return or the write data is accepted.
module mem_arbiter #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128,
  parameter int READ_BEATS    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ic_req_valid,
  output logic                       ic_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
  input  logic                       ic_req_rw,
  input  logic                       ic_req_data_valid,
  output logic                       ic_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                       ic_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   ic_resp_data,
  input  logic                       dc_req_valid,
  output logic                       dc_req_ready,
  input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic                       dc_req_rw,
  input  logic                       dc_req_data_valid,
  output logic                       dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                       dc_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   dc_resp_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int BEAT_W = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(READ_BEATS - 1);

  typedef enum logic [1:0] {IDLE, WDATA, RESP} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic sel, src;
  logic src_valid, src_rw, src_dvalid;
  logic req_rdy, data_rdy;

  // Tie goes to whoever did not win the last completed handshake.
  always_comb begin
    if (ic_req_valid && !dc_req_valid)      sel = 1'b0;
    else if (dc_req_valid && !ic_req_valid) sel = 1'b1;
    else if (ic_req_valid && dc_req_valid)  sel = ~last_grant_q;
    else                                    sel = 1'b0;
  end

  assign src        = (state_q == IDLE) ? sel : owner_q;
  assign src_valid  = src ? dc_req_valid      : ic_req_valid;
  assign src_rw     = src ? dc_req_rw         : ic_req_rw;
  assign src_dvalid = src ? dc_req_data_valid : ic_req_data_valid;

  assign mem_req_addr      = src ? dc_req_addr      : ic_req_addr;
  assign mem_req_rw        = src_rw;
  assign mem_req_data_bits = src ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask = src ? dc_req_data_mask : ic_req_data_mask;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    req_rdy            = 1'b0;
    data_rdy           = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_valid      = src_valid;
        mem_req_data_valid = src_valid & src_rw & src_dvalid & mem_req_ready;
        req_rdy            = src_valid & mem_req_ready;
        data_rdy           = src_valid & src_rw & mem_req_ready & mem_req_data_ready;
      end
      WDATA: begin
        mem_req_data_valid = src_dvalid;
        data_rdy           = mem_req_data_ready;
      end
      default: ;
    endcase
  end

  assign ic_req_ready      = req_rdy & ~src;
  assign dc_req_ready      = req_rdy & src;
  assign ic_req_data_ready = data_rdy & ~src;
  assign dc_req_data_ready = data_rdy & src;

  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;
  assign ic_resp_valid = (state_q == RESP) & ~owner_q & mem_resp_valid;
  assign dc_resp_valid = (state_q == RESP) &  owner_q & mem_resp_valid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_req_valid && mem_req_ready) begin
          owner_d      = sel;
          last_grant_d = sel;
          if (!src_rw) begin
            state_d    = RESP;
            beat_cnt_d = '0;
          end else if (!(mem_req_data_valid && mem_req_data_ready)) begin
            state_d = WDATA;
          end
        end
      end
      WDATA: if (mem_req_data_valid && mem_req_data_ready) state_d = IDLE;
      RESP: begin
        if (mem_resp_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reads, writes, round-robin,
// hold-off while busy, memory back-pressure and asynchronous reset.
module tb_mem_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
  logic [27:0]   ic_req_addr;
  logic [127:0]  ic_req_data_bits, ic_resp_data;
  logic [15:0]   ic_req_data_mask;
  logic          ic_resp_valid;
  logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
  logic [27:0]   dc_req_addr;
  logic [127:0]  dc_req_data_bits, dc_resp_data;
  logic [15:0]   dc_req_data_mask;
  logic          dc_resp_valid;
  logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [27:0]   mem_req_addr;
  logic [127:0]  mem_req_data_bits, mem_resp_data;
  logic [15:0]   mem_req_data_mask;
  logic          mem_resp_valid;

  int errs = 0;
  int checks = 0;

  mem_arbiter #(.MEM_ADDR_BITS(28), .MEM_DATA_BITS(128), .READ_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
    .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
    .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid),
    .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
    .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_rw = 0; ic_req_addr = '0; ic_req_data_valid = 0;
    ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_data_valid = 0;
    dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  // Feeds READ_BEATS response beats and expects them all routed to one client.
  task automatic drain(input bit to_dc, input logic [127:0] base, input string tag);
    for (int b = 0; b < 4; b++) begin
      mem_resp_valid = 1; mem_resp_data = base + 128'(b);
      #1;
      checks++;
      if ((to_dc ? dc_resp_valid : ic_resp_valid) !== 1'b1 ||
          (to_dc ? ic_resp_valid : dc_resp_valid) !== 1'b0 ||
          (to_dc ? dc_resp_data : ic_resp_data) !== base + 128'(b)) begin
        errs++;
        $display("FAIL %s beat %0d: ic_v=%b dc_v=%b data=%h, want to_dc=%b data=%h",
                 tag, b, ic_resp_valid, dc_resp_valid, to_dc ? dc_resp_data : ic_resp_data,
                 to_dc, base + 128'(b));
      end
      checks++;
      if (mem_req_valid !== 1'b0 || ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0) begin
        errs++;
        $display("FAIL %s busy beat %0d: mem_req_valid=%b ic_rdy=%b dc_rdy=%b, want 0 0 0",
                 tag, b, mem_req_valid, ic_req_ready, dc_req_ready);
      end
      tick();
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    mem_resp_valid = 1; mem_resp_data = 128'hDEAD;
    tick(); tick();
    reset = 0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready, ic_req_data_ready,
         dc_req_data_ready, ic_resp_valid, dc_resp_valid} !== 8'h00) begin
      errs++;
      $display("FAIL reset_idle_outputs: got %b, want 00000000",
               {mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready,
                ic_req_data_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid});
    end
    tick();
    checks++;
    if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_stray_beat: ic_v=%b dc_v=%b, want 0 0", ic_resp_valid, dc_resp_valid);
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_ic_read();
    ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h0000123; mem_req_ready = 1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0000123 || mem_req_rw !== 1'b0 ||
        ic_req_ready !== 1'b1 || dc_req_ready !== 1'b0) begin
      errs++;
      $display("FAIL ic_read_fwd: v=%b addr=%h rw=%b ic_rdy=%b dc_rdy=%b, want 1 0000123 0 1 0",
               mem_req_valid, mem_req_addr, mem_req_rw, ic_req_ready, dc_req_ready);
    end
    tick();
    ic_req_valid = 0;
    #1;
    checks++;
    if (ic_resp_valid !== 1'b0) begin
      errs++;
      $display("FAIL ic_read_gap: ic_resp_valid=%b with no beat, want 0", ic_resp_valid);
    end
    tick();
    drain(1'b0, 128'hD0, "ic_read");
    mem_resp_valid = 1;
    #1;
    checks++;
    if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
      errs++;
      $display("FAIL ic_read_extra_beat: ic_v=%b dc_v=%b, want 0 0", ic_resp_valid, dc_resp_valid);
    end
    tick();
    mem_resp_valid = 0;
  endtask

  task automatic test_dc_write();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h00000AB; dc_req_data_valid = 1;
    dc_req_data_bits = {128{1'b1}}; dc_req_data_mask = 16'hFFFF;
    mem_req_ready = 1; mem_req_data_ready = 1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 28'h00000AB ||
        mem_req_data_valid !== 1'b1 || mem_req_data_bits !== {128{1'b1}} ||
        mem_req_data_mask !== 16'hFFFF) begin
      errs++;
      $display("FAIL dc_write_fwd: v=%b rw=%b addr=%h dv=%b mask=%h, want 1 1 00000AB 1 FFFF",
               mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid, mem_req_data_mask);
    end
    checks++;
    if (dc_req_ready !== 1'b1 || dc_req_data_ready !== 1'b1 || ic_req_ready !== 1'b0) begin
      errs++;
      $display("FAIL dc_write_ready: dc_rdy=%b dc_drdy=%b ic_rdy=%b, want 1 1 0",
               dc_req_ready, dc_req_data_ready, ic_req_ready);
    end
    tick();
    // Still IDLE: a fresh request must be forwarded at once.
    dc_req_addr = 28'h00000AC; dc_req_data_ready_hold();
  endtask

  task automatic dc_req_data_ready_hold();
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h00000AC || dc_req_ready !== 1'b1) begin
      errs++;
      $display("FAIL dc_write_stay_idle: v=%b addr=%h dc_rdy=%b, want 1 00000AC 1",
               mem_req_valid, mem_req_addr, dc_req_ready);
    end
  endtask

  task automatic test_dc_write_stall();
    // Continues from test_dc_write: request 0xAC handshakes now, data held off 3 cycles.
    mem_req_data_ready = 0;
    #1;
    checks++;
    if (mem_req_data_valid !== 1'b1 || dc_req_data_ready !== 1'b0) begin
      errs++;
      $display("FAIL stall_c0: dv=%b dc_drdy=%b, want 1 0", mem_req_data_valid, dc_req_data_ready);
    end
    tick();
    dc_req_valid = 0; ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h0000777;
    for (int c = 1; c < 3; c++) begin
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || ic_req_ready !== 1'b0 || mem_req_data_valid !== 1'b1 ||
          dc_req_data_ready !== 1'b0 || mem_req_data_mask !== 16'hFFFF) begin
        errs++;
        $display("FAIL stall_c%0d: v=%b ic_rdy=%b dv=%b dc_drdy=%b mask=%h, want 0 0 1 0 FFFF",
                 c, mem_req_valid, ic_req_ready, mem_req_data_valid, dc_req_data_ready,
                 mem_req_data_mask);
      end
      tick();
    end
    ic_req_valid = 0; mem_req_data_ready = 1;
    #1;
    checks++;
    if (dc_req_data_ready !== 1'b1 || mem_req_data_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_accept: dc_drdy=%b dv=%b v=%b, want 1 1 0",
               dc_req_data_ready, mem_req_data_valid, mem_req_valid);
    end
    tick();
    dc_req_data_valid = 0;
    #1;
    checks++;
    if (dc_req_data_ready !== 1'b0 || mem_req_data_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_done: dc_drdy=%b dv=%b, want 0 0", dc_req_data_ready, mem_req_data_valid);
    end
    dc_req_rw = 0; mem_req_data_ready = 0;
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    ic_req_valid = 1; ic_req_addr = 28'h0000100;
    dc_req_valid = 1; dc_req_addr = 28'h0000200;
    mem_req_ready = 1;
    for (int g = 0; g < 4; g++) begin
      bit exp_dc;
      exp_dc = (g % 2 == 0);
      #1;
      checks++;
      if (mem_req_addr !== (exp_dc ? 28'h0000200 : 28'h0000100) ||
          dc_req_ready !== exp_dc || ic_req_ready !== !exp_dc) begin
        errs++;
        $display("FAIL rr_grant%0d: addr=%h ic_rdy=%b dc_rdy=%b, want dc=%b",
                 g, mem_req_addr, ic_req_ready, dc_req_ready, exp_dc);
      end
      tick();
      drain(exp_dc, 128'h1000 * 128'(g + 1), "rr");
    end
    ic_req_valid = 0; dc_req_valid = 0;
  endtask

  task automatic test_busy_holdoff();
    dc_req_valid = 1; dc_req_addr = 28'h0000300; mem_req_ready = 1;
    tick();
    dc_req_valid = 0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1; mem_resp_data = 128'hA0 + 128'(b);
      tick();
    end
    ic_req_valid = 1; ic_req_addr = 28'h0000400;
    for (int b = 2; b < 4; b++) begin
      mem_resp_valid = 1; mem_resp_data = 128'hA0 + 128'(b);
      #1;
      checks++;
      if (ic_req_ready !== 1'b0 || mem_req_valid !== 1'b0 || dc_resp_valid !== 1'b1 ||
          ic_resp_valid !== 1'b0) begin
        errs++;
        $display("FAIL holdoff_beat%0d: ic_rdy=%b v=%b dc_v=%b ic_v=%b, want 0 0 1 0",
                 b, ic_req_ready, mem_req_valid, dc_resp_valid, ic_resp_valid);
      end
      tick();
    end
    mem_resp_valid = 0;
    #1;
    checks++;
    if (ic_req_ready !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0000400) begin
      errs++;
      $display("FAIL holdoff_grant: ic_rdy=%b v=%b addr=%h, want 1 1 0000400",
               ic_req_ready, mem_req_valid, mem_req_addr);
    end
    tick();
    ic_req_valid = 0;
    drain(1'b0, 128'hB0, "holdoff_ic");
  endtask

  task automatic test_mem_not_ready();
    // last_grant is ic here, so a tie selects dc and must stay on dc while stalled.
    mem_req_ready = 0;
    ic_req_valid = 1; ic_req_addr = 28'h00000A0;
    dc_req_valid = 1; dc_req_addr = 28'h00000B0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h00000B0 ||
          ic_req_ready !== 1'b0 || dc_req_ready !== 1'b0) begin
        errs++;
        $display("FAIL notready_c%0d: v=%b addr=%h ic_rdy=%b dc_rdy=%b, want 1 00000B0 0 0",
                 c, mem_req_valid, mem_req_addr, ic_req_ready, dc_req_ready);
      end
      tick();
    end
    mem_req_ready = 1;
    #1;
    checks++;
    if (dc_req_ready !== 1'b1 || mem_req_addr !== 28'h00000B0) begin
      errs++;
      $display("FAIL notready_grant: dc_rdy=%b addr=%h, want 1 00000B0", dc_req_ready, mem_req_addr);
    end
    tick();
    dc_req_valid = 0;
    drain(1'b1, 128'hC0, "notready_dc");
    #1;
    checks++;
    if (ic_req_ready !== 1'b1 || mem_req_addr !== 28'h00000A0) begin
      errs++;
      $display("FAIL notready_ic_next: ic_rdy=%b addr=%h, want 1 00000A0", ic_req_ready, mem_req_addr);
    end
    tick();
    ic_req_valid = 0;
    drain(1'b0, 128'hE0, "notready_ic");
  endtask

  task automatic test_async_reset();
    ic_req_valid = 1; ic_req_addr = 28'h0000555; mem_req_ready = 1;
    tick();
    ic_req_valid = 0;
    mem_resp_valid = 1; mem_resp_data = 128'hF0;
    #1;
    checks++;
    if (ic_resp_valid !== 1'b1) begin
      errs++;
      $display("FAIL areset_first_beat: ic_v=%b, want 1", ic_resp_valid);
    end
    tick();
    mem_resp_data = 128'hF1;
    #2;
    reset = 1;
    #1;
    checks++;
    if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
      errs++;
      $display("FAIL areset_immediate: ic_v=%b dc_v=%b, want 0 0", ic_resp_valid, dc_resp_valid);
    end
    tick();
    reset = 0;
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++;
      if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0) begin
        errs++;
        $display("FAIL areset_stale%0d: ic_v=%b dc_v=%b, want 0 0", b, ic_resp_valid, dc_resp_valid);
      end
      tick();
    end
    mem_resp_valid = 0;
    dc_req_valid = 1; dc_req_addr = 28'h0000777;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || dc_req_ready !== 1'b1 || mem_req_addr !== 28'h0000777) begin
      errs++;
      $display("FAIL areset_next_req: v=%b dc_rdy=%b addr=%h, want 1 1 0000777",
               mem_req_valid, dc_req_ready, mem_req_addr);
    end
    tick();
    dc_req_valid = 0;
    drain(1'b1, 128'h2000, "areset_dc");
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_dc_write_stall();
    test_back_to_back();
    test_busy_holdoff();
    test_mem_not_ready();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client memory arbiter. It sits directly downstream of the instruction cache and the data cache, and drives the single external memory port.
- Each client uses the cache-side memory interface: request, write-data and response channels.
- It grants one client at a time, using round-robin on ties.
- It holds the grant until the transaction completes: all read beats returned, or write data accepted. Read responses go back only to the owning client.

Parameters:
- MEM_ADDR_BITS, 28, memory word-address width (cache WORD_ADDR_BITS minus 2).
- MEM_DATA_BITS, 128, memory data width (`MEM_DATA_BITS).
- READ_BEATS, 4, response beats returned per accepted read request.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ic_req_valid / dc_req_valid  in  1  client request valid
- ic_req_ready / dc_req_ready  out  1  client request accepted
- ic_req_addr / dc_req_addr  in  MEM_ADDR_BITS  client request address
- ic_req_rw / dc_req_rw  in  1  1 = write, 0 = read
- ic_req_data_valid / dc_req_data_valid  in  1  client write data valid
- ic_req_data_ready / dc_req_data_ready  out  1  client write data accepted
- ic_req_data_bits / dc_req_data_bits  in  MEM_DATA_BITS  client write data
- ic_req_data_mask / dc_req_data_mask  in  MEM_DATA_BITS/8  client byte mask
- ic_resp_valid / dc_resp_valid  out  1  response beat for this client
- ic_resp_data / dc_resp_data  out  MEM_DATA_BITS  response data (broadcast)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request ready
- mem_req_addr  out  MEM_ADDR_BITS  memory request address
- mem_req_rw  out  1  memory read/write select
- mem_req_data_valid  out  1  memory write data valid
- mem_req_data_ready  in  1  memory write data ready
- mem_req_data_bits  out  MEM_DATA_BITS  memory write data
- mem_req_data_mask  out  MEM_DATA_BITS/8  memory byte mask
- mem_resp_valid  in  1  memory response beat valid
- mem_resp_data  in  MEM_DATA_BITS  memory response data

Behaviour:
- Registered state: state {IDLE, WDATA, RESP}, owner (0 = ic, 1 = dc), last_grant, beat_cnt (clog2(READ_BEATS) bits).
- Reset (asynchronous, active-high) sets state=IDLE, owner=0, last_grant=0 (ic), beat_cnt=0.
- All outputs are combinational from state, owner and inputs. With no client valid in IDLE, every valid/ready output is 0.
- The arbiter adds zero latency: the selected client's fields pass straight through to memory in the same cycle.
- IDLE selection (sel): only ic valid -> ic; only dc valid -> dc; both valid -> the client != last_grant.
- IDLE forwarding:
  - mem_req_valid = sel valid; addr, rw, data and mask come from sel.
  - sel req_ready = mem_req_ready; the other client's ready = 0.
  - mem_req_data_valid = sel req_valid & sel rw & sel data_valid & mem_req_ready. Data is never accepted ahead of its request.
- IDLE on request handshake (mem_req_valid & mem_req_ready): owner<=sel, last_grant<=sel. Then:
  - read -> RESP, beat_cnt<=0;
  - write with a data handshake in the same cycle -> stay IDLE;
  - write without a data handshake -> WDATA.
- WDATA:
  - mem_req_valid=0; mem_req_data_valid = owner data_valid; data and mask come from owner.
  - owner data_ready = mem_req_data_ready; the other client's ready = 0.
  - Data handshake -> IDLE.
- RESP:
  - mem_req_valid=0; both req_ready=0.
  - Each mem_resp_valid: owner resp_valid=1 that cycle, beat_cnt++.
  - The beat with beat_cnt==READ_BEATS-1 -> IDLE, beat_cnt<=0. The next grant can happen on the following cycle.
- Response routing:
  - resp_data for both clients = mem_resp_data.
  - A resp_valid is asserted only in RESP and only to owner.
  - mem_resp_valid seen in IDLE or WDATA (e.g. stray beats after reset) is dropped.
- Simultaneous events:
  - A request from the non-owner while busy is held off with ready=0. The client keeps valid high; it is granted in IDLE.
  - Both valid in IDLE while memory is not ready: sel stays stable, because last_grant updates only on a handshake.
- Reset mid-operation: returns to IDLE at once and in-flight beats are discarded. Clients are also reset, so there is no replay.

Test Plan:
- ic read alone, addr 28'h0000123, mem_req_ready=1 -> mem_req_addr=28'h0000123, rw=0. Four mem_resp_valid beats D0..D3 -> ic_resp_valid exactly 4 cycles with D0..D3; dc_resp_valid stays 0.
- dc write, addr 28'h00000AB, data 128'hF..F, mask 16'hFFFF, with both readies 1 -> one-cycle handshake, stays IDLE. Repeat with mem_req_data_ready=0 for 3 cycles -> WDATA until ready, dc_req_data_ready=1 only on the accept cycle.
- ic and dc reads both valid from reset -> dc granted first (last_grant=ic). After its 4 beats, ic is granted. Repeated back-to-back ties -> dc, ic, dc, ic.
- dc read in RESP after 2 beats, ic_req_valid asserted -> ic_req_ready=0 and mem_req_valid=0 until the dc 4th beat. ic is granted the next cycle.
- mem_req_ready=0 for 5 cycles with ic pending -> no state change, last_grant unchanged, then normal grant.
- reset asserted asynchronously mid-RESP after 1 beat -> state IDLE at once, later mem_resp_valid beats produce no client resp_valid, next request is handled normally.
